// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the execute-stage multiply/divide unit.
// Holds RV32M decode constants, datapath widths, the mdu state encoding
// and the per-operation context latched when an operation is accepted.
package cpu_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 5;
    localparam int unsigned F3_W  = 3;

    localparam logic [6:0] OPC_RTYPE     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [F3_W-1:0] F3_MUL    = 3'b000;
    localparam logic [F3_W-1:0] F3_MULH   = 3'b001;
    localparam logic [F3_W-1:0] F3_MULHSU = 3'b010;
    localparam logic [F3_W-1:0] F3_MULHU  = 3'b011;
    localparam logic [F3_W-1:0] F3_DIV    = 3'b100;
    localparam logic [F3_W-1:0] F3_DIVU   = 3'b101;
    localparam logic [F3_W-1:0] F3_REM    = 3'b110;
    localparam logic [F3_W-1:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_RUN  = 2'd1,
        MDU_FIX  = 2'd2,
        MDU_DONE = 2'd3
    } mdu_state_t;

    // Everything the FIX step needs about the operation, captured at accept.
    typedef struct packed {
        logic [F3_W-1:0] funct3;
        logic            sign_a;
        logic            sign_b;
        logic            is_div;
        logic            is_rem;
        logic            div_by_zero;
        logic            signed_overflow;
    } mdu_ctx_t;

    // Two's-complement negate when requested.
    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v,
                                                 input logic            neg);
        return neg ? (~v + XLEN'(1)) : v;
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/response bus between pipeline control and the multiply/divide unit.
//   start, kill, funct3, op_a, op_b : request side (driven by master)
//   busy, done, result              : response side (driven by slave)
interface mul_div_unit_if;
    import cpu_pkg::*;

    logic                  start;
    logic                  kill;
    logic [F3_W-1:0]       funct3;
    logic [XLEN-1:0]       op_a;
    logic [XLEN-1:0]       op_b;
    logic                  busy;
    logic                  done;
    logic [XLEN-1:0]       result;

    modport master (
        output start, kill, funct3, op_a, op_b,
        input  busy, done, result
    );

    modport slave (
        input  start, kill, funct3, op_a, op_b,
        output busy, done, result
    );

endinterface

// File: rtl/mdu_operand_prep.sv
// Combinational operand preparation for the multiply/divide unit.
//   funct3, op_a, op_b     : decoded operation and raw operands
//   sign_a_c, sign_b_c     : operand is treated as signed and is negative
//   mag_a_c, mag_b_c       : unsigned magnitudes (0x80000000 -> 2^31)
//   is_div_c, is_rem_c     : operation class
//   div_by_zero_c          : divide-class op with zero divisor
//   signed_overflow_c      : DIV/REM of 0x80000000 by -1
module mdu_operand_prep
    import cpu_pkg::*;
(
    input  logic [F3_W-1:0] funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            sign_a_c,
    output logic            sign_b_c,
    output logic [XLEN-1:0] mag_a_c,
    output logic [XLEN-1:0] mag_b_c,
    output logic            is_div_c,
    output logic            is_rem_c,
    output logic            div_by_zero_c,
    output logic            signed_overflow_c
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic signed_a;
    logic signed_b;

    // Which operands are interpreted as signed for this funct3.
    always_comb begin
        signed_a = 1'b0;
        signed_b = 1'b0;
        case (funct3)
            F3_MULH, F3_DIV, F3_REM: begin
                signed_a = 1'b1;
                signed_b = 1'b1;
            end
            F3_MULHSU: signed_a = 1'b1;
            default: ;
        endcase
    end

    // Magnitudes and special-case flags.
    always_comb begin
        sign_a_c          = signed_a & op_a[XLEN-1];
        sign_b_c          = signed_b & op_b[XLEN-1];
        mag_a_c           = cond_neg(op_a, sign_a_c);
        mag_b_c           = cond_neg(op_b, sign_b_c);
        is_div_c          = funct3[2];
        is_rem_c          = funct3[2] & funct3[1];
        div_by_zero_c     = funct3[2] & (op_b == '0);
        signed_overflow_c = funct3[2] & signed_b & (op_a == INT_MIN) & (&op_b);
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit (execute stage).
// Fixed 33-cycle latency from accept to done for every operation:
// 32 shift-add or restoring-divide iterations, then one sign-fix cycle.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : slave side of mul_div_unit_if (start/kill/funct3/op_a/op_b in,
//              busy/done/result out)
module mul_div_unit
    import cpu_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    mul_div_unit_if.slave  bus
);

    localparam int unsigned ACC_W = 2 * XLEN;

    mdu_state_t       state;
    mdu_state_t       state_d;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_d;
    logic             busy_q;
    logic             busy_d;
    logic             done_q;
    logic             done_d;
    logic             accept;
    logic             step;
    logic             fix_en;

    mdu_ctx_t         ctx;
    logic [XLEN-1:0]  addend;
    logic [ACC_W-1:0] acc;
    logic [XLEN:0]    rem;
    logic [XLEN-1:0]  result_q;

    logic             sign_a_c;
    logic             sign_b_c;
    logic [XLEN-1:0]  mag_a_c;
    logic [XLEN-1:0]  mag_b_c;
    logic             is_div_c;
    logic             is_rem_c;
    logic             div_by_zero_c;
    logic             signed_overflow_c;

    mdu_operand_prep u_prep (
        .funct3            (bus.funct3),
        .op_a              (bus.op_a),
        .op_b              (bus.op_b),
        .sign_a_c          (sign_a_c),
        .sign_b_c          (sign_b_c),
        .mag_a_c           (mag_a_c),
        .mag_b_c           (mag_b_c),
        .is_div_c          (is_div_c),
        .is_rem_c          (is_rem_c),
        .div_by_zero_c     (div_by_zero_c),
        .signed_overflow_c (signed_overflow_c)
    );

    // State, iteration counter and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= MDU_IDLE;
            count  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_d;
            count  <= count_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    // Next-state and control strobes; kill overrides everything.
    always_comb begin
        state_d = state;
        count_d = count;
        accept  = 1'b0;
        step    = 1'b0;
        fix_en  = 1'b0;
        case (state)
            MDU_IDLE, MDU_DONE: begin
                state_d = MDU_IDLE;
                if (bus.start && !bus.kill) begin
                    accept  = 1'b1;
                    state_d = MDU_RUN;
                    count_d = '0;
                end
            end
            MDU_RUN: begin
                step    = !bus.kill;
                count_d = count + CNT_W'(1);
                if (count == CNT_W'(XLEN - 1)) begin
                    state_d = MDU_FIX;
                end
            end
            MDU_FIX: begin
                fix_en  = !bus.kill;
                state_d = MDU_DONE;
            end
            default: state_d = MDU_IDLE;
        endcase
        if (bus.kill) begin
            state_d = MDU_IDLE;
            count_d = '0;
        end
        busy_d = (state_d == MDU_RUN) || (state_d == MDU_FIX);
        done_d = (state_d == MDU_DONE);
    end

    // One shift-add step: acc = {partial product hi, remaining multiplier bits}.
    logic [XLEN:0]    mul_sum;
    logic [ACC_W-1:0] mul_next;
    // One restoring-divide step: acc[XLEN-1:0] shifts dividend out, quotient in.
    logic [XLEN+1:0]  div_shift;
    logic [XLEN:0]    div_diff;
    logic             div_fits;

    always_comb begin
        mul_sum   = {1'b0, acc[ACC_W-1:XLEN]} + {1'b0, (acc[0] ? addend : '0)};
        mul_next  = {mul_sum, acc[XLEN-1:1]};
        div_shift = {rem, acc[XLEN-1]};
        div_diff  = div_shift[XLEN:0] - {1'b0, addend};
        div_fits  = div_shift >= {2'b00, addend};
    end

    // Sign correction and result selection for the FIX cycle.
    logic [ACC_W-1:0] prod;
    logic [XLEN-1:0]  quo_s;
    logic [XLEN-1:0]  rem_s;
    logic [XLEN-1:0]  fix_value;

    always_comb begin
        fix_value = '0;
        prod      = (ctx.sign_a ^ ctx.sign_b) ? (~acc + ACC_W'(1)) : acc;
        quo_s     = cond_neg(acc[XLEN-1:0], ctx.sign_a ^ ctx.sign_b);
        rem_s     = cond_neg(rem[XLEN-1:0], ctx.sign_a);
        if (!ctx.is_div) begin
            fix_value = (ctx.funct3 == F3_MUL) ? prod[XLEN-1:0] : prod[ACC_W-1:XLEN];
        end else if (ctx.div_by_zero) begin
            // Remainder path already holds |op_a|, so rem_s restores op_a.
            fix_value = ctx.is_rem ? rem_s : '1;
        end else if (ctx.signed_overflow) begin
            fix_value = ctx.is_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end else begin
            fix_value = ctx.is_rem ? rem_s : quo_s;
        end
    end

    // Operand capture, iteration datapath and result register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctx      <= '0;
            addend   <= '0;
            acc      <= '0;
            rem      <= '0;
            result_q <= '0;
        end else begin
            if (accept) begin
                ctx.funct3          <= bus.funct3;
                ctx.sign_a          <= sign_a_c;
                ctx.sign_b          <= sign_b_c;
                ctx.is_div          <= is_div_c;
                ctx.is_rem          <= is_rem_c;
                ctx.div_by_zero     <= div_by_zero_c;
                ctx.signed_overflow <= signed_overflow_c;
                addend              <= is_div_c ? mag_b_c : mag_a_c;
                acc                 <= {{XLEN{1'b0}}, (is_div_c ? mag_a_c : mag_b_c)};
                rem                 <= '0;
            end else if (step) begin
                if (ctx.is_div) begin
                    rem            <= div_fits ? div_diff : div_shift[XLEN:0];
                    acc[XLEN-1:0]  <= {acc[XLEN-2:0], div_fits};
                end else begin
                    acc <= mul_next;
                end
            end
            if (fix_en) begin
                result_q <= fix_value;
            end
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed RV32M cases, handshake
// corner cases and randomized operations against an arithmetic reference.
module tb_mul_div_unit;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mul_div_unit_if bus ();

    mul_div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_result = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model straight from the RV32M definitions.
    function automatic logic [31:0] ref_model(input logic [2:0] f3,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        logic signed [31:0] ia, ib, q;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        ia = a;
        ib = b;
        p  = '0;
        q  = '0;
        case (f3)
            3'b000: begin p = ua * ub; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                q = ia / ib;
                return q;
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                q = ia % ib;
                return q;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h1;
            4:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Present a request for one edge, then scramble the inputs (don't-care).
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = f3;
        bus.op_a   = a;
        bus.op_b   = b;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.funct3 = 3'($urandom);
        bus.op_a   = $urandom;
        bus.op_b   = $urandom;
    endtask

    // Cycles from the current sample point until done, bounded.
    task automatic wait_done(output int lat, output int busy_cycles);
        lat         = -1;
        busy_cycles = bus.busy ? 1 : 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.busy) busy_cycles++;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic count_done(input int cycles, output int pulses);
        pulses = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) pulses++;
        end
    endtask

    task automatic run_check(input string tag, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] b);
        int          lat, bc;
        logic [31:0] exp;
        exp = ref_model(f3, a, b);
        issue(f3, a, b);
        wait_done(lat, bc);
        check({tag, " latency"}, 32'(lat), 32'd33);
        check({tag, " busy_cycles"}, 32'(bc), 32'd33);
        check({tag, " result"}, bus.result, exp);
        @(posedge clk);
        #1;
        check({tag, " done_pulse"}, 32'(bus.done), 32'd0);
        last_result = exp;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          lat, bc, pulses;
        logic [2:0]  f3;
        logic [31:0] a, b, exp;

        bus.start  = 1'b0;
        bus.kill   = 1'b0;
        bus.funct3 = '0;
        bus.op_a   = '0;
        bus.op_b   = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset result", bus.result, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        run_check("mul 7*-3", F3_MUL, 32'd7, 32'hFFFF_FFFD);
        check("mul 7*-3 const", last_result, 32'hFFFF_FFEB);
        run_check("mulh min*min", F3_MULH, 32'h8000_0000, 32'h8000_0000);
        check("mulh min*min const", bus.result, 32'h4000_0000);
        run_check("mulhu max*max", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("mulhu max*max const", bus.result, 32'hFFFF_FFFE);
        run_check("mulhsu -1*max", F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("mulhsu -1*max const", bus.result, 32'hFFFF_FFFF);
        run_check("div -7/2", F3_DIV, 32'hFFFF_FFF9, 32'd2);
        check("div -7/2 const", bus.result, 32'hFFFF_FFFD);
        run_check("rem -7/2", F3_REM, 32'hFFFF_FFF9, 32'd2);
        check("rem -7/2 const", bus.result, 32'hFFFF_FFFF);
        run_check("divu 100/7", F3_DIVU, 32'd100, 32'd7);
        check("divu 100/7 const", bus.result, 32'd14);
        run_check("remu 100/7", F3_REMU, 32'd100, 32'd7);
        check("remu 100/7 const", bus.result, 32'd2);
        run_check("div 5/0", F3_DIV, 32'd5, 32'd0);
        check("div 5/0 const", bus.result, 32'hFFFF_FFFF);
        run_check("remu 5/0", F3_REMU, 32'd5, 32'd0);
        check("remu 5/0 const", bus.result, 32'd5);
        run_check("rem -5/0", F3_REM, 32'hFFFF_FFFB, 32'd0);
        run_check("div min/-1", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div min/-1 const", bus.result, 32'h8000_0000);
        run_check("rem min/-1", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF);
        check("rem min/-1 const", bus.result, 32'h0);

        // Second start while busy is ignored and not queued.
        exp = ref_model(F3_MUL, 32'd7, 32'd9);
        issue(F3_MUL, 32'd7, 32'd9);
        bus.start  = 1'b1;
        bus.funct3 = F3_DIVU;
        bus.op_a   = 32'd100;
        bus.op_b   = 32'd7;
        repeat (5) @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(lat, bc);
        check("busy start latency", 32'(lat), 32'd28);
        check("busy start result", bus.result, exp);
        last_result = exp;
        count_done(40, pulses);
        check("busy start no queue", 32'(pulses), 32'd0);
        check("busy start result held", bus.result, exp);

        // kill at RUN count=10 aborts without touching result.
        issue(F3_MULHU, 32'hDEAD_BEEF, 32'h1234_5678);
        repeat (10) @(posedge clk);
        #1;
        bus.kill = 1'b1;
        @(posedge clk);
        #1;
        bus.kill = 1'b0;
        check("kill busy", 32'(bus.busy), 32'd0);
        check("kill done", 32'(bus.done), 32'd0);
        count_done(40, pulses);
        check("kill no done", 32'(pulses), 32'd0);
        check("kill result kept", bus.result, last_result);

        // kill wins over start in IDLE.
        @(negedge clk);
        bus.start = 1'b1;
        bus.kill  = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        check("kill over start busy", 32'(bus.busy), 32'd0);

        // start during the DONE cycle is accepted back-to-back.
        issue(F3_DIVU, 32'd100, 32'd7);
        wait_done(lat, bc);
        check("chain first latency", 32'(lat), 32'd33);
        check("chain first result", bus.result, 32'd14);
        issue(F3_REMU, 32'd100, 32'd7);
        check("chain accept busy", 32'(bus.busy), 32'd1);
        check("chain accept done", 32'(bus.done), 32'd0);
        wait_done(lat, bc);
        check("chain second latency", 32'(lat), 32'd33);
        check("chain second result", bus.result, 32'd2);

        // Randomized operations.
        for (int i = 0; i < 60; i++) begin
            f3 = 3'($urandom);
            a  = pick_operand();
            b  = pick_operand();
            run_check($sformatf("rand%0d f3=%0d a=%h b=%h", i, f3, a, b), f3, a, b);
        end

        // Asynchronous reset mid-RUN, between edges.
        issue(F3_MULH, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("async rst busy", 32'(bus.busy), 32'd0);
        check("async rst done", 32'(bus.done), 32'd0);
        check("async rst result", bus.result, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        count_done(40, pulses);
        check("async rst no done", 32'(pulses), 32'd0);
        run_check("post rst mulhu 3*5", F3_MULHU, 32'd3, 32'd5);
        check("post rst mulhu const", bus.result, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
